race_controller: RTL and testbench

- Race-sequencing block that drives the lap timer's `start`, `lap_finished` and `stop` inputs; it is the initiator side of the lap-timer control interface.
- Runs a 3-2-1 countdown on a start request, then watches car position against a finish-line rectangle and a mid-track checkpoint rectangle.
- Issues one-cycle control pulses and ends the race after a configured lap count.
- Sits between the car/position logic and the lap timer, all in the pclk domain.

---
 rtl/race_controller.sv | 166 ++++++++++++++++
 tb/tb_race_controller.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/race_controller.sv
// Race sequencer: 3-2-1 countdown, then checkpoint-gated lap detection at the finish line.
// Drives one-cycle start / lap_finished / stop pulses towards the lap timer.
module race_controller #(
  parameter int unsigned TICKS_PER_SEC = 65_000_000,
  parameter int unsigned LAPS          = 3,
  parameter int unsigned FIN_X0        = 100,
  parameter int unsigned FIN_X1        = 140,
  parameter int unsigned FIN_Y0        = 300,
  parameter int unsigned FIN_Y1        = 420,
  parameter int unsigned CP_X0         = 800,
  parameter int unsigned CP_X1         = 840,
  parameter int unsigned CP_Y0         = 300,
  parameter int unsigned CP_Y1         = 420
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        start_req,
  input  logic        abort,
  input  logic [11:0] car_x,
  input  logic [11:0] car_y,
  output logic        start,
  output logic        lap_finished,
  output logic        stop,
  output logic [1:0]  countdown,
  output logic [3:0]  lap_count,
  output logic        race_active,
  output logic        race_done
);

  localparam int unsigned TickW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_SEC - 1);
  localparam logic [3:0] LapsTarget = 4'(LAPS);

  localparam logic [11:0] FinX0 = 12'(FIN_X0);
  localparam logic [11:0] FinX1 = 12'(FIN_X1);
  localparam logic [11:0] FinY0 = 12'(FIN_Y0);
  localparam logic [11:0] FinY1 = 12'(FIN_Y1);
  localparam logic [11:0] CpX0  = 12'(CP_X0);
  localparam logic [11:0] CpX1  = 12'(CP_X1);
  localparam logic [11:0] CpY0  = 12'(CP_Y0);
  localparam logic [11:0] CpY1  = 12'(CP_Y1);

  typedef enum logic [1:0] {StIdle, StCountdown, StRacing, StFinished} state_e;

  state_e           state_q, state_d;
  logic [1:0]       countdown_q, countdown_d;
  logic [3:0]       lap_count_q, lap_count_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic             cp_seen_q, cp_seen_d;
  logic             in_fin_q;
  logic             start_q, start_d;
  logic             lap_q, lap_d;
  logic             stop_q, stop_d;
  logic             active_q, done_q;

  logic       in_fin, in_cp, fin_entry;
  logic [3:0] lap_inc;

  assign in_fin = (car_x >= FinX0) && (car_x <= FinX1) && (car_y >= FinY0) && (car_y <= FinY1);
  assign in_cp  = (car_x >= CpX0) && (car_x <= CpX1) && (car_y >= CpY0) && (car_y <= CpY1);
  assign fin_entry = in_fin & ~in_fin_q;
  assign lap_inc   = lap_count_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    countdown_d = countdown_q;
    lap_count_d = lap_count_q;
    tick_d      = tick_q;
    cp_seen_d   = cp_seen_q;
    start_d     = 1'b0;
    lap_d       = 1'b0;
    stop_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d     = StCountdown;
          countdown_d = 2'd3;
          tick_d      = '0;
        end
      end
      StCountdown: begin
        if (abort) begin
          state_d     = StIdle;
          countdown_d = 2'd0;
          tick_d      = '0;
        end else if (tick_q == TickLast) begin
          tick_d      = '0;
          countdown_d = countdown_q - 2'd1;
          if (countdown_q == 2'd1) begin
            state_d     = StRacing;
            start_d     = 1'b1;
            cp_seen_d   = 1'b0;
            lap_count_d = 4'd0;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StRacing: begin
        if (abort) begin
          state_d = StIdle;
          stop_d  = 1'b1;
        end else begin
          if (in_cp) cp_seen_d = 1'b1;
          // Lap qualification looks at cp_seen from before this cycle's update.
          if (fin_entry && cp_seen_q) begin
            lap_d       = 1'b1;
            lap_count_d = lap_inc;
            cp_seen_d   = 1'b0;
            if (lap_inc == LapsTarget) begin
              stop_d  = 1'b1;
              state_d = StFinished;
            end
          end
        end
      end
      StFinished: begin
        if (abort) begin
          state_d = StIdle;
        end else if (start_req) begin
          state_d     = StCountdown;
          countdown_d = 2'd3;
          tick_d      = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_q     <= StIdle;
      countdown_q <= 2'd0;
      lap_count_q <= 4'd0;
      tick_q      <= '0;
      cp_seen_q   <= 1'b0;
      in_fin_q    <= 1'b1;  // no false entry if the car sits on the line at reset
      start_q     <= 1'b0;
      lap_q       <= 1'b0;
      stop_q      <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      countdown_q <= countdown_d;
      lap_count_q <= lap_count_d;
      tick_q      <= tick_d;
      cp_seen_q   <= cp_seen_d;
      in_fin_q    <= in_fin;
      start_q     <= start_d;
      lap_q       <= lap_d;
      stop_q      <= stop_d;
      active_q    <= (state_d == StRacing);
      done_q      <= (state_d == StFinished);
    end
  end

  assign start        = start_q;
  assign lap_finished = lap_q;
  assign stop         = stop_q;
  assign countdown    = countdown_q;
  assign lap_count    = lap_count_q;
  assign race_active  = active_q;
  assign race_done    = done_q;

endmodule

// File: tb/tb_race_controller.sv
// Bench for race_controller: level checks inside each scenario task, and a pulse
// scoreboard that pops an expected lap_finished/stop event whenever a pulse appears.
module tb_race_controller;

  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic        start_req = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] car_x = 12'd120;
  logic [11:0] car_y = 12'd350;
  logic        start, lap_finished, stop, race_active, race_done;
  logic [1:0]  countdown;
  logic [3:0]  lap_count;

  typedef struct packed {
    logic       lf;
    logic       stp;
    logic [3:0] lc;
    logic       done;
  } ev_t;

  ev_t exp_q[$];
  int  tests_run = 0;
  int  tests_failed = 0;

  race_controller #(
    .TICKS_PER_SEC(4),
    .LAPS         (2)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .start_req   (start_req),
    .abort       (abort),
    .car_x       (car_x),
    .car_y       (car_y),
    .start       (start),
    .lap_finished(lap_finished),
    .stop        (stop),
    .countdown   (countdown),
    .lap_count   (lap_count),
    .race_active (race_active),
    .race_done   (race_done)
  );

  always #5 pclk = ~pclk;

  // Scoreboard consumer: every lap_finished/stop pulse must match the oldest expectation.
  always @(posedge pclk) begin
    ev_t e;
    ev_t o;
    #2;
    if (lap_finished || stop) begin
      o = {lap_finished, stop, lap_count, race_done};
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL pulse_unexpected: got %b expected no pulse", o);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          tests_failed++;
          $display("FAIL pulse_event: got %b expected %b", o, e);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic set_car(input int x);
    car_x = 12'(x);
    car_y = 12'd350;
  endtask

  task automatic begin_race();
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    step(12);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start_req = 1'b1;
    set_car(120);
    step(3);
    tests_run++;
    if ({start, lap_finished, stop, countdown, lap_count, race_active, race_done} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 0",
               {start, lap_finished, stop, countdown, lap_count, race_active, race_done});
    end
    start_req = 1'b0;
    rst = 1'b1;
    step(3);
    tests_run++;
    if ({race_active, race_done, countdown, lap_count} !== 8'd0) begin
      tests_failed++;
      $display("FAIL idle_after_release: got %b expected 0",
               {race_active, race_done, countdown, lap_count});
    end
  endtask

  task automatic test_countdown();
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    tests_run++;
    if ({countdown, start} !== 3'b110) begin
      tests_failed++;
      $display("FAIL countdown_3: got %b expected 110", {countdown, start});
    end
    step(4);
    tests_run++;
    if (countdown !== 2'd2) begin
      tests_failed++;
      $display("FAIL countdown_2: got %0d expected 2", countdown);
    end
    step(4);
    tests_run++;
    if ({countdown, race_active, start} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL countdown_1: got %b expected 0100", {countdown, race_active, start});
    end
    step(4);
    tests_run++;
    if ({countdown, start, race_active, lap_count} !== 8'b00_1_1_0000) begin
      tests_failed++;
      $display("FAIL countdown_go: got %b expected 00110000",
               {countdown, start, race_active, lap_count});
    end
    step();
    tests_run++;
    if (start !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_one_cycle: got %b expected 0", start);
    end
  endtask

  task automatic test_valid_laps();
    set_car(820);
    step();
    set_car(120);
    exp_q.push_back('{lf: 1'b1, stp: 1'b0, lc: 4'd1, done: 1'b0});
    step();
    tests_run++;
    if (lap_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL lap1_count: got %0d expected 1", lap_count);
    end
    step();
    set_car(820);
    step();
    set_car(120);
    exp_q.push_back('{lf: 1'b1, stp: 1'b1, lc: 4'd2, done: 1'b1});
    step();
    tests_run++;
    if ({race_done, race_active} !== 2'b10) begin
      tests_failed++;
      $display("FAIL finished_state: got %b expected 10", {race_done, race_active});
    end
    step(2);
    set_car(820);
    step();
    set_car(120);
    step(2);
    tests_run++;
    if ({lap_count, race_done} !== 5'b0010_1) begin
      tests_failed++;
      $display("FAIL finished_holds: got %b expected 00101", {lap_count, race_done});
    end
  endtask

  task automatic test_restart();
    set_car(500);
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    tests_run++;
    if ({countdown, lap_count, race_done} !== 7'b11_0010_0) begin
      tests_failed++;
      $display("FAIL restart_countdown: got %b expected 1100100", {countdown, lap_count, race_done});
    end
    step(11);
    tests_run++;
    if (lap_count !== 4'd2) begin
      tests_failed++;
      $display("FAIL restart_lap_hold: got %0d expected 2", lap_count);
    end
    step();
    tests_run++;
    if ({start, lap_count} !== 5'b1_0000) begin
      tests_failed++;
      $display("FAIL restart_clear: got %b expected 10000", {start, lap_count});
    end
  endtask

  task automatic test_cheat();
    for (int i = 0; i < 2; i++) begin
      set_car(120);
      step();
      set_car(500);
      step();
    end
    tests_run++;
    if ({lap_count, race_active} !== 5'b0000_1) begin
      tests_failed++;
      $display("FAIL cheat_no_lap: got %b expected 00001", {lap_count, race_active});
    end
  endtask

  task automatic test_abort();
    bit saw_start;
    set_car(820);
    step();
    set_car(120);
    exp_q.push_back('{lf: 1'b1, stp: 1'b0, lc: 4'd1, done: 1'b0});
    step();
    set_car(500);
    step();
    abort = 1'b1;
    exp_q.push_back('{lf: 1'b0, stp: 1'b1, lc: 4'd1, done: 1'b0});
    step();
    abort = 1'b0;
    tests_run++;
    if ({race_active, race_done, countdown, lap_count} !== 8'b0_0_00_0001) begin
      tests_failed++;
      $display("FAIL abort_racing: got %b expected 00000001",
               {race_active, race_done, countdown, lap_count});
    end
    step();
    tests_run++;
    if (stop !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_stop_once: got %b expected 0", stop);
    end
    // abort must beat a lap-completing finish entry in the same cycle
    begin_race();
    set_car(820);
    step();
    set_car(500);
    step();
    set_car(120);
    abort = 1'b1;
    exp_q.push_back('{lf: 1'b0, stp: 1'b1, lc: 4'd0, done: 1'b0});
    step();
    abort = 1'b0;
    tests_run++;
    if ({lap_count, race_active} !== 5'd0) begin
      tests_failed++;
      $display("FAIL abort_beats_lap: got %b expected 00000", {lap_count, race_active});
    end
    set_car(500);
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    step(2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests_run++;
    if ({countdown, race_active, start} !== 4'd0) begin
      tests_failed++;
      $display("FAIL abort_countdown: got %b expected 0000", {countdown, race_active, start});
    end
    saw_start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      saw_start |= start | race_active;
    end
    tests_run++;
    if (saw_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_countdown_idle: got %b expected 0", saw_start);
    end
  endtask

  task automatic test_midrace_reset();
    begin_race();
    set_car(820);
    step();
    rst = 1'b0;
    step();
    tests_run++;
    if ({start, lap_finished, stop, countdown, lap_count, race_active, race_done} !== 11'd0) begin
      tests_failed++;
      $display("FAIL midrace_reset: got %b expected 0",
               {start, lap_finished, stop, countdown, lap_count, race_active, race_done});
    end
    rst = 1'b1;
    step(2);
    tests_run++;
    if ({race_active, countdown} !== 3'd0) begin
      tests_failed++;
      $display("FAIL midrace_reset_idle: got %b expected 000", {race_active, countdown});
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_valid_laps();
    test_restart();
    test_cheat();
    test_abort();
    test_midrace_reset();
    step(3);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL pulse_pending: got %0d outstanding expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
